// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-ported data memory: port 0 has fixed
// priority, a starvation counter guarantees port 1 progress, responses are registered.
module dmem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int DEPTH      = 1024,
  parameter int STARVE_MAX = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              p0_req,
  input  logic                              p0_we,
  input  logic [AW-1:0]                     p0_addr,
  input  logic [DW-1:0]                     p0_wdata,
  input  logic                              p1_req,
  input  logic                              p1_we,
  input  logic [AW-1:0]                     p1_addr,
  input  logic [DW-1:0]                     p1_wdata,
  output logic                              p0_gnt,
  output logic                              p1_gnt,
  output logic                              p0_rvalid,
  output logic [DW-1:0]                     p0_rdata,
  output logic                              p0_err,
  output logic                              p1_rvalid,
  output logic [DW-1:0]                     p1_rdata,
  output logic                              p1_err,
  output logic [AW-1:0]                     mem_A,
  output logic [DW-1:0]                     mem_WD,
  output logic                              mem_WE,
  input  logic [DW-1:0]                     mem_RD,
  output logic [$clog2(STARVE_MAX+1)-1:0]   dbg_starve_cnt_o
);

  localparam int            CW         = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_SAT = CW'(STARVE_MAX);
  localparam logic [AW-1:0] DEPTH_A    = AW'(DEPTH);

  // Handshake: req/we/addr/wdata are held by the requester until gnt (the
  // "ready"); the access completes in the gnt cycle and the requester may move
  // on in the next cycle. rvalid is a single-cycle pulse one cycle after gnt.

  logic [CW-1:0] starve_q, starve_d;
  logic          p1_wins, any_gnt, sel_we, in_range;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata, resp_rdata;

  logic          p0_rvalid_q, p0_rvalid_d, p1_rvalid_q, p1_rvalid_d;
  logic          p0_err_q, p0_err_d, p1_err_q, p1_err_d;
  logic [DW-1:0] p0_rdata_q, p0_rdata_d, p1_rdata_q, p1_rdata_d;

  always_comb begin
    p1_wins   = p1_req && (!p0_req || (starve_q == STARVE_SAT));
    p0_gnt    = p0_req && !p1_wins;
    p1_gnt    = p1_wins;
    any_gnt   = p0_req || p1_req;
    sel_addr  = p1_wins ? p1_addr  : p0_addr;
    sel_wdata = p1_wins ? p1_wdata : p0_wdata;
    sel_we    = p1_wins ? p1_we    : p0_we;
    in_range  = sel_addr < DEPTH_A;

    mem_A  = any_gnt ? sel_addr  : '0;
    mem_WD = any_gnt ? sel_wdata : '0;
    // Out-of-range writes and writes during reset never reach the array.
    mem_WE = any_gnt && sel_we && in_range && !rst;
  end

  always_comb begin
    starve_d = '0;
    if (p1_req && !p1_wins) begin
      starve_d = (starve_q == STARVE_SAT) ? starve_q : starve_q + CW'(1);
    end
  end

  always_comb begin
    resp_rdata  = (any_gnt && !sel_we && in_range) ? mem_RD : '0;
    p0_rvalid_d = p0_gnt;
    p0_rdata_d  = p0_gnt ? resp_rdata : '0;
    p0_err_d    = p0_gnt && !in_range;
    p1_rvalid_d = p1_gnt;
    p1_rdata_d  = p1_gnt ? resp_rdata : '0;
    p1_err_d    = p1_gnt && !in_range;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q    <= '0;
      p0_rvalid_q <= 1'b0;
      p0_rdata_q  <= '0;
      p0_err_q    <= 1'b0;
      p1_rvalid_q <= 1'b0;
      p1_rdata_q  <= '0;
      p1_err_q    <= 1'b0;
    end else begin
      starve_q    <= starve_d;
      p0_rvalid_q <= p0_rvalid_d;
      p0_rdata_q  <= p0_rdata_d;
      p0_err_q    <= p0_err_d;
      p1_rvalid_q <= p1_rvalid_d;
      p1_rdata_q  <= p1_rdata_d;
      p1_err_q    <= p1_err_d;
    end
  end

  assign p0_rvalid        = p0_rvalid_q;
  assign p0_rdata         = p0_rdata_q;
  assign p0_err           = p0_err_q;
  assign p1_rvalid        = p1_rvalid_q;
  assign p1_rdata         = p1_rdata_q;
  assign p1_err           = p1_err_q;
  assign dbg_starve_cnt_o = starve_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table for the corner cases, then
// random traffic against a transaction-level model with a shadow memory.
module tb_dmem_arbiter;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 1024;
  localparam int SMAX  = 4;
  localparam int CW    = $clog2(SMAX + 1);
  localparam int IW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst;
  logic          p0_req, p0_we, p1_req, p1_we;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [DW-1:0] p0_wdata, p1_wdata;
  logic          p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err;
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic [AW-1:0] mem_A;
  logic [DW-1:0] mem_WD, mem_RD;
  logic          mem_WE;
  logic [CW-1:0] dbg_starve_cnt;

  dmem_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p0_gnt(p0_gnt), .p1_gnt(p1_gnt),
    .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE), .mem_RD(mem_RD),
    .dbg_starve_cnt_o(dbg_starve_cnt)
  );

  always #5 clk = ~clk;

  // Memory array behind the arbiter; upper address bits alias like real hardware.
  logic          mem_init;
  logic [DW-1:0] mem [DEPTH];
  assign mem_RD = (mem_A < 32'(DEPTH)) ? mem[mem_A[IW-1:0]] : 32'hBAD0_BAD0;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h1000_0000 + 32'(i);
    end else if (mem_WE) begin
      mem[mem_A[IW-1:0]] <= mem_WD;
    end
  end

  typedef struct {
    logic          rst, r0, w0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          r1, w1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic          eg0, eg1, ewe;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic          erv0;
    logic [DW-1:0] erd0;
    logic          eerr0, erv1;
    logic [DW-1:0] erd1;
    logic          eerr1;
    logic [CW-1:0] ecnt;
  } vec_t;

  int            n_checks = 0;
  int            n_fail   = 0;
  int            cyc      = 0;
  int            streak   = 0;
  logic [DW-1:0] ref_mem [DEPTH];
  vec_t          tbl [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic vec_t mk(logic rst, r0, w0, logic [31:0] a0, d0,
                              logic r1, w1, logic [31:0] a1, d1,
                              logic eg0, eg1, ewe, erv0, logic [31:0] erd0, logic eerr0,
                              logic erv1, logic [31:0] erd1, logic eerr1, int ecnt);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.eg0 = eg0; v.eg1 = eg1; v.ewe = ewe; v.ea = '0; v.ed = '0;
    v.erv0 = erv0; v.erd0 = erd0; v.eerr0 = eerr0;
    v.erv1 = erv1; v.erd1 = erd1; v.eerr1 = eerr1;
    v.ecnt = CW'(ecnt);
    return v;
  endfunction

  // Which port the rules award this cycle: -1 none, else port number.
  function automatic int winner(vec_t v);
    if (v.r0 && v.r1) return (streak >= SMAX) ? 1 : 0;
    if (v.r1) return 1;
    if (v.r0) return 0;
    return -1;
  endfunction

  function automatic vec_t predict(vec_t v);
    vec_t          m = v;
    int            w;
    logic [AW-1:0] a [2];
    logic [DW-1:0] d [2];
    logic          we [2];
    logic [DW-1:0] rd;
    bit            inr;
    a[0] = v.a0;  a[1] = v.a1;
    d[0] = v.d0;  d[1] = v.d1;
    we[0] = v.w0; we[1] = v.w1;
    w = winner(v);
    m.eg0 = (w == 0); m.eg1 = (w == 1);
    m.ewe = 0; m.ea = '0; m.ed = '0;
    m.erv0 = 0; m.erd0 = '0; m.eerr0 = 0;
    m.erv1 = 0; m.erd1 = '0; m.eerr1 = 0;
    if (w >= 0) begin
      inr  = a[w] < 32'(DEPTH);
      m.ea = a[w];
      m.ed = d[w];
      m.ewe = we[w] && inr && !v.rst;
      if (!v.rst) begin
        rd = (!we[w] && inr) ? ref_mem[a[w][IW-1:0]] : '0;
        if (w == 0) begin m.erv0 = 1; m.erd0 = rd; m.eerr0 = !inr; end
        else        begin m.erv1 = 1; m.erd1 = rd; m.eerr1 = !inr; end
      end
    end
    if (v.rst || !v.r1 || w == 1) m.ecnt = '0;
    else m.ecnt = CW'((streak >= SMAX) ? SMAX : streak + 1);
    return m;
  endfunction

  task automatic apply(input vec_t v, input bit use_tbl);
    vec_t m, e;
    int   w;
    rst = v.rst;
    p0_req = v.r0; p0_we = v.w0; p0_addr = v.a0; p0_wdata = v.d0;
    p1_req = v.r1; p1_we = v.w1; p1_addr = v.a1; p1_wdata = v.d1;
    m = predict(v);
    e = use_tbl ? v : m;
    #2;
    check("p0_gnt", p0_gnt, e.eg0);
    check("p1_gnt", p1_gnt, e.eg1);
    check("mem_WE", mem_WE, e.ewe);
    check("mem_A", mem_A, m.ea);
    check("mem_WD", mem_WD, m.ed);
    @(posedge clk);
    w = winner(v);
    if (!v.rst && w == 0 && v.w0 && v.a0 < 32'(DEPTH)) ref_mem[v.a0[IW-1:0]] = v.d0;
    if (!v.rst && w == 1 && v.w1 && v.a1 < 32'(DEPTH)) ref_mem[v.a1[IW-1:0]] = v.d1;
    streak = int'(m.ecnt);
    #1;
    check("p0_rvalid", p0_rvalid, e.erv0);
    check("p1_rvalid", p1_rvalid, e.erv1);
    check("starve_cnt", dbg_starve_cnt, e.ecnt);
    if (e.erv0 || v.rst) begin
      check("p0_rdata", p0_rdata, e.erd0);
      check("p0_err", p0_err, e.eerr0);
    end
    if (e.erv1 || v.rst) begin
      check("p1_rdata", p1_rdata, e.erd1);
      check("p1_err", p1_err, e.eerr1);
    end
    cyc++;
    @(negedge clk);
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    if ($urandom_range(0, 9) == 0) return 32'(1020 + $urandom_range(0, 8));
    return 32'($urandom_range(0, 15));
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h1000_0000 + 32'(i);
    mem_init = 1'b1; rst = 1'b1;
    p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
    p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
    @(negedge clk);
    mem_init = 1'b0;

    // Reset, with both ports trying to write while reset is held.
    tbl.push_back(mk(1, 0,0,0,0,                0,0,0,0,            0,0,0, 0,0,0, 0,0,0, 0));
    tbl.push_back(mk(1, 1,1,7,'hAAAA,           1,1,8,'hBBBB,       1,0,0, 0,0,0, 0,0,0, 0));
    tbl.push_back(mk(1, 1,1,7,'hAAAA,           1,1,8,'hBBBB,       1,0,0, 0,0,0, 0,0,0, 0));
    // Port 0 write then read-back of the same address.
    tbl.push_back(mk(0, 1,1,5,'hDEADBEEF,       0,0,0,0,            1,0,1, 1,0,0, 0,0,0, 0));
    tbl.push_back(mk(0, 1,0,5,0,                0,0,0,0,            1,0,0, 1,'hDEADBEEF,0, 0,0,0, 0));
    // Continuous contention: p0 x4 then p1, twice.
    for (int i = 0; i < 10; i++) begin
      if (i % 5 < 4)
        tbl.push_back(mk(0, 1,0,3,0, 1,0,4,0, 1,0,0, 1,'h1000_0003,0, 0,0,0, (i % 5) + 1));
      else
        tbl.push_back(mk(0, 1,0,3,0, 1,0,4,0, 0,1,0, 0,0,0, 1,'h1000_0004,0, 0));
    end
    tbl.push_back(mk(0, 0,0,0,0,                0,0,0,0,            0,0,0, 0,0,0, 0,0,0, 0));
    // Out-of-range write on port 1, then memory word 0 must be untouched.
    tbl.push_back(mk(0, 0,0,0,0,                1,1,1024,'h12345678, 0,1,0, 0,0,0, 1,0,1, 0));
    tbl.push_back(mk(0, 1,0,0,0,                0,0,0,0,            1,0,0, 1,'h1000_0000,0, 0,0,0, 0));
    tbl.push_back(mk(0, 1,0,2000,0,             0,0,0,0,            1,0,0, 1,0,1, 0,0,0, 0));
    // Port 1 alone, then port 0 joins and takes priority.
    tbl.push_back(mk(0, 0,0,0,0,                1,0,6,0,            0,1,0, 0,0,0, 1,'h1000_0006,0, 0));
    tbl.push_back(mk(0, 0,0,0,0,                1,0,6,0,            0,1,0, 0,0,0, 1,'h1000_0006,0, 0));
    tbl.push_back(mk(0, 1,0,5,0,                1,0,6,0,            1,0,0, 1,'hDEADBEEF,0, 0,0,0, 1));
    tbl.push_back(mk(0, 1,0,5,0,                1,0,6,0,            1,0,0, 1,'hDEADBEEF,0, 0,0,0, 2));
    // Reset during a port-0 write grant: no commit, no response.
    tbl.push_back(mk(1, 1,1,9,'hCAFEF00D,       0,0,0,0,            1,0,0, 0,0,0, 0,0,0, 0));
    tbl.push_back(mk(0, 1,0,9,0,                0,0,0,0,            1,0,0, 1,'h1000_0009,0, 0,0,0, 0));
    tbl.push_back(mk(0, 0,0,0,0,                1,0,9,0,            0,1,0, 0,0,0, 1,'h1000_0009,0, 0));

    foreach (tbl[i]) apply(tbl[i], 1'b1);

    for (int i = 0; i < 400; i++) begin
      v = mk(0, 0,0,0,0, 0,0,0,0, 0,0,0, 0,0,0, 0,0,0, 0);
      v.rst = ($urandom_range(0, 39) == 0);
      v.r0  = ($urandom_range(0, 2) != 0);
      v.w0  = 1'($urandom_range(0, 1));
      v.a0  = rnd_addr();
      v.d0  = $urandom;
      v.r1  = 1'($urandom_range(0, 1));
      v.w1  = 1'($urandom_range(0, 1));
      v.a1  = rnd_addr();
      v.d1  = $urandom;
      apply(v, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter and sequencer in front of the single-ported data memory. Shares the memory's one address/write-data/write-enable port between the pipeline MEM stage (port 0) and a secondary master such as a debug loader or DMA engine (port 1). Port 0 has fixed priority, with a starvation counter that guarantees port 1 forward progress. The arbiter registers read data and response status for the granted requester. It sits between the MEM stage/loader and the data memory block.

## Interface
- `AW`, default 32: address width of both requesters and of the memory address.
- `DW`, default 32: data width.
- `DEPTH`, default 1024: number of memory words; valid addresses are 0..DEPTH-1.
- `STARVE_MAX`, default 4: number of consecutive denied port-1 cycles after which port 1 wins the next contention.
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `p0_req`, `p1_req` in 1: access request, level. Held until granted.
- `p0_we`, `p1_we` in 1: 1 = write, 0 = read. Valid with req.
- `p0_addr`, `p1_addr` in AW: word address. Valid with req.
- `p0_wdata`, `p1_wdata` in DW: write data. Valid with req and we.
- `p0_gnt`, `p1_gnt` out 1: combinational. Access accepted this cycle.
- `p0_rvalid`, `p1_rvalid` out 1: registered one-cycle response pulse.
- `p0_rdata`, `p1_rdata` out DW: registered read data. Valid while rvalid.
- `p0_err`, `p1_err` out 1: registered. Out-of-range access flag, valid while rvalid.
- `mem_A` out AW: drives memory `A`.
- `mem_WD` out DW: drives memory `WD`.
- `mem_WE` out 1: drives memory `WE`.
- `mem_RD` in DW: memory combinational read data.

## Operation
- One access per cycle, at most. The grant decision is combinational from the req inputs and `starve_cnt`.
- Arbitration:
  - If only one port requests, that port is granted.
  - If both request, port 0 wins unless `starve_cnt == STARVE_MAX`; in that case port 1 wins.
  - If neither requests, there is no grant.
- Starvation counter `starve_cnt` has width clog2(STARVE_MAX+1):
  - Increments on each cycle with `p1_req` asserted and `p1_gnt` low.
  - Saturates at STARVE_MAX.
  - Clears to 0 on a `p1_gnt` cycle, or on any cycle with `p1_req` low.
- Memory drive:
  - The granted port's addr and wdata are muxed onto `mem_A` and `mem_WD`.
  - `mem_WE` = granted we AND address in range.
  - With no grant: `mem_A` = 0, `mem_WD` = 0, `mem_WE` = 0.
- Out-of-range access (addr >= DEPTH):
  - It is granted normally.
  - `mem_WE` is forced to 0.
  - The response carries rdata = 0 and err = 1.
- Response register, loaded at the edge ending each grant cycle:
  - rvalid of the granted port = 1.
  - rdata = `mem_RD` for an in-range read, else 0. Writes return 0.
  - err = out-of-range.
  - The non-granted port's rvalid = 0.
- Writes also produce an rvalid pulse, which serves as a write acknowledge.

## Timing
- Reset values: all rvalid, rdata, and err outputs = 0, and `starve_cnt` = 0. Gnt and `mem_*` follow the inputs combinationally; with req low they are 0.
- Reset mid-operation: an asserted `rst` overrides the response load, so no rvalid is issued for a grant in the reset cycle. The memory write in that cycle is also suppressed: `mem_WE` = 0 while `rst` = 1.
- Latency:
  - Grant is in the same cycle as req (cycle N).
  - A write commits at the end of cycle N.
  - The response appears in cycle N+1 for exactly one cycle.
- Back-to-back:
  - A port holding req continuously while it keeps winning is granted every cycle, giving one response per cycle.
  - A read in cycle N+1 of an address written in cycle N returns the new data.
- Handshake:
  - The requester must hold req, we, addr, and wdata stable until gnt.
  - The requester may change them or drop req in the cycle after gnt.
  - The arbiter does not check for a req drop before gnt; an access that is never granted is simply abandoned.
- Simultaneous events:
  - A port-1 grant and a port-1 req drop in the same cycle clear the counter.
  - Counter saturation never wraps.

## Test plan
- Reset: hold `rst` for 2 cycles with both req = 1 and we = 1 -> `mem_WE` = 0, all rvalid = 0, and `starve_cnt` = 0 after release.
- Single port 0: write 0xDEADBEEF to address 5, then read address 5 in the next cycle -> `p0_gnt` is high in both cycles, and `p0_rvalid` follows each by one cycle. The read returns `p0_rdata` = 0xDEADBEEF with `p0_err` = 0.
- Contention with STARVE_MAX = 4: both ports request reads continuously -> the grant pattern is p0,p0,p0,p0,p1 repeating, `p1_rvalid` appears every 5th cycle, and the counter resets after each p1 grant.
- Out of range: port 1 writes 0x12345678 to address 1024 -> `p1_gnt` = 1 and `mem_WE` = 0. The next cycle gives `p1_rvalid` = 1 and `p1_err` = 1. A read of address 0 afterwards shows the memory is unchanged.
- Priority on a fresh request: port 1 requests alone for 2 cycles, then port 0 joins -> port 1 is granted in the first cycle, then port 0 wins from the contention cycle onward, and `starve_cnt` starts counting from 0.
- Reset mid-traffic: assert `rst` in the cycle of a port-0 write grant -> the write is not committed, there is no `p0_rvalid` in the next cycle, and normal arbitration resumes on the first cycle after release.
